reg_file_mp: RTL and testbench

- Multi-port, parametrised integer register file for the single-cycle core and its planned dual-issue successor.
- Provides NUM_RD independent registered read ports and NUM_WR write ports.
- Register 0 is hardwired to zero.
- Same-address write collisions are resolved deterministically and flagged.

---
 rtl/reg_file_mp.sv | 94 +++++++++
 tb/tb_reg_file_mp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports, NUM_WR write ports, reg 0 hardwired to zero.
// Define REG_FILE_MP_BYPASS_EN for write-first reads; the default build is read-first.

module reg_file_mp_rd_port #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  word,
  output logic [WIDTH-1:0]  data
);
  always_ff @(posedge clk) begin
    if (rst)
      data <= '0;
    else if (en)
      data <= (addr == '0) ? '0 : word;
  end
endmodule

module reg_file_mp #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic                     wr_collision
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] regs, regs_nxt, rd_src;

  // Post-write image; later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    regs_nxt = regs;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k])
        regs_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*WIDTH +: WIDTH];
    regs_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else
      regs <= regs_nxt;
  end

`ifdef REG_FILE_MP_BYPASS_EN
  assign rd_src = regs_nxt;
`else
  assign rd_src = regs;
`endif

  generate
    if (NUM_WR > 1) begin : g_coll
      logic [ADDR_W-1:0] a0, a1;
      logic              coll_now;
      assign a0       = wr_addr[0 +: ADDR_W];
      assign a1       = wr_addr[ADDR_W +: ADDR_W];
      assign coll_now = wr_en[0] && wr_en[1] && (a0 == a1) && (a0 != '0);

      always_ff @(posedge clk) begin
        if (rst)
          wr_collision <= 1'b0;
        else if (coll_now)
          wr_collision <= 1'b1;
      end
    end else begin : g_no_coll
      assign wr_collision = 1'b0;
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      reg_file_mp_rd_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rd (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_en[j]),
        .addr (rd_addr[j*ADDR_W +: ADDR_W]),
        .word (rd_src[rd_addr[j*ADDR_W +: ADDR_W]]),
        .data (rd_data[j*WIDTH +: WIDTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default instance plus a 64-bit/16-entry/3-read/1-write instance,
// both driven from one stimulus stream and compared to an array-based reference model.

module tb_reg_file_mp;
`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Abstract stimulus shared by both instances
  logic        s_rst;
  logic [1:0]  s_we;
  logic [4:0]  s_wa [2];
  logic [63:0] s_wd [2];
  logic [2:0]  s_re;
  logic [4:0]  s_ra [3];

  logic [9:0]   a_wr_addr, a_rd_addr;
  logic [63:0]  a_wr_data, a_rd_data;
  logic         a_col;
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic         b_col;

  assign a_wr_addr = {s_wa[1], s_wa[0]};
  assign a_wr_data = {s_wd[1][31:0], s_wd[0][31:0]};
  assign a_rd_addr = {s_ra[1], s_ra[0]};
  assign b_rd_addr = {s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]};

  reg_file_mp dut_a (
    .clk(clk), .rst(s_rst),
    .wr_en(s_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(s_re[1:0]), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_collision(a_col)
  );

  reg_file_mp #(.WIDTH(64), .ADDR_W(4), .NUM_RD(3), .NUM_WR(1)) dut_b (
    .clk(clk), .rst(s_rst),
    .wr_en(s_we[0]), .wr_addr(s_wa[0][3:0]), .wr_data(s_wd[0]),
    .rd_en(s_re), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_collision(b_col)
  );

  // Reference model: index 0 = default instance, 1 = sweep instance
  logic [63:0] m_mem [2][32];
  logic [63:0] m_rd  [2][3];
  logic        m_col [2];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Apply current stimulus to the model, then clock the DUTs.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      int nwr, nrd, am, a0, a1, a;
      logic [63:0] wm;
      logic [63:0] old [32];
      nwr = d ? 1 : 2;
      nrd = d ? 3 : 2;
      am  = d ? 15 : 31;
      wm  = d ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      if (s_rst) begin
        for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
        for (int j = 0; j < 3; j++) m_rd[d][j] = '0;
        m_col[d] = 1'b0;
      end else begin
        for (int i = 0; i < 32; i++) old[i] = m_mem[d][i];
        for (int k = 0; k < nwr; k++) begin
          a = int'(s_wa[k]) & am;
          if (s_we[k] && a != 0) m_mem[d][a] = s_wd[k] & wm;
        end
        a0 = int'(s_wa[0]) & am;
        a1 = int'(s_wa[1]) & am;
        if (nwr == 2 && s_we == 2'b11 && a0 == a1 && a0 != 0) m_col[d] = 1'b1;
        for (int j = 0; j < nrd; j++) begin
          a = int'(s_ra[j]) & am;
          if (s_re[j]) m_rd[d][j] = (a == 0) ? 64'h0 : (BYP ? m_mem[d][a] : old[a]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag);
    for (int j = 0; j < 2; j++)
      check($sformatf("%s.a.rd%0d", tag, j), {32'h0, a_rd_data[j*32 +: 32]}, m_rd[0][j]);
    check($sformatf("%s.a.col", tag), {63'h0, a_col}, {63'h0, m_col[0]});
    for (int j = 0; j < 3; j++)
      check($sformatf("%s.b.rd%0d", tag, j), b_rd_data[j*64 +: 64], m_rd[1][j]);
    check($sformatf("%s.b.col", tag), {63'h0, b_col}, {63'h0, m_col[1]});
  endtask

  task automatic idle();
    s_rst = 1'b0; s_we = '0; s_re = '0;
  endtask

  initial begin
    s_rst = 1'b1; s_we = '0; s_re = '0;
    for (int k = 0; k < 2; k++) begin s_wa[k] = '0; s_wd[k] = '0; end
    for (int j = 0; j < 3; j++) s_ra[j] = '0;

    // 1. reset, all addresses read zero
    step(); step();
    cmp("reset");
    idle();
    for (int i = 0; i < 32; i++) begin
      s_re = 3'b111; s_ra[0] = 5'(i); s_ra[1] = 5'(31 - i); s_ra[2] = 5'(i + 7);
      step();
      cmp($sformatf("zero%0d", i));
    end
    idle(); s_we = 2'b01; s_wa[0] = 5'd0; s_wd[0] = 64'hDEAD_BEEF;
    step();
    idle(); s_re = 3'b001; s_ra[0] = 5'd0;
    step();
    check("addr0", {32'h0, a_rd_data[31:0]}, 64'h0);

    // 2. fill and readback
    for (int i = 1; i < 32; i++) begin
      idle(); s_we = 2'b01; s_wa[0] = 5'(i); s_wd[0] = 64'(4 * (i + 1));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      idle(); s_re = 3'b111;
      s_ra[0] = 5'(2 * i); s_ra[1] = 5'(2 * i + 1); s_ra[2] = 5'(i);
      step();
      cmp($sformatf("fill%0d", i));
      if (i == 3) begin
        check("fill.addr6", {32'h0, a_rd_data[31:0]}, 64'h1C);
        check("fill.addr7", {32'h0, a_rd_data[63:32]}, 64'h20);
      end
    end

    // 3. dual write, then collision on addr 5
    idle(); s_we = 2'b11; s_wa[0] = 5'd3; s_wd[0] = 64'h11; s_wa[1] = 5'd4; s_wd[1] = 64'h22;
    step();
    idle(); s_re = 3'b011; s_ra[0] = 5'd3; s_ra[1] = 5'd4;
    step();
    check("dual.p0", {32'h0, a_rd_data[31:0]}, 64'h11);
    check("dual.p1", {32'h0, a_rd_data[63:32]}, 64'h22);
    check("dual.col", {63'h0, a_col}, 64'h0);
    idle(); s_we = 2'b11; s_wa[0] = 5'd5; s_wd[0] = 64'hAA; s_wa[1] = 5'd5; s_wd[1] = 64'hBB;
    step();
    idle(); s_re = 3'b001; s_ra[0] = 5'd5;
    step();
    check("coll.data", {32'h0, a_rd_data[31:0]}, 64'hBB);
    check("coll.flag", {63'h0, a_col}, 64'h1);
    cmp("coll");
    idle();
    for (int i = 0; i < 10; i++) step();
    check("coll.sticky", {63'h0, a_col}, 64'h1);

    // 4. read during write on addr 9
    idle(); s_we = 2'b01; s_wa[0] = 5'd9; s_wd[0] = 64'h100;
    step();
    idle(); s_we = 2'b01; s_wa[0] = 5'd9; s_wd[0] = 64'h200; s_re = 3'b001; s_ra[0] = 5'd9;
    step();
    check("rdw.same", {32'h0, a_rd_data[31:0]}, BYP ? 64'h200 : 64'h100);
    cmp("rdw");
    idle(); s_re = 3'b001; s_ra[0] = 5'd9;
    step();
    check("rdw.next", {32'h0, a_rd_data[31:0]}, 64'h200);

    // 5. hold, then reset overriding a write
    idle(); s_ra[0] = 5'd3; s_ra[1] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp($sformatf("hold%0d", i));
    end
    idle(); s_rst = 1'b1; s_we = 2'b01; s_wa[0] = 5'd10; s_wd[0] = 64'h55;
    step();
    idle(); s_re = 3'b111; s_ra[0] = 5'd10; s_ra[1] = 5'd10; s_ra[2] = 5'd10;
    step();
    check("rstwr.data", {32'h0, a_rd_data[31:0]}, 64'h0);
    check("rstwr.col", {63'h0, a_col}, 64'h0);
    cmp("rstwr");

    // Randomized traffic with a narrow address range to provoke collisions and bypass hits
    for (int i = 0; i < 300; i++) begin
      s_rst = ($urandom_range(0, 59) == 0);
      s_we  = 2'($urandom);
      s_re  = 3'($urandom);
      for (int k = 0; k < 2; k++) begin
        s_wa[k] = 5'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 5'h10 : 5'h0);
        s_wd[k] = {$urandom, $urandom};
      end
      for (int j = 0; j < 3; j++) s_ra[j] = 5'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 5'h10 : 5'h0);
      step();
      cmp($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
